device_axil_bridge: RTL and testbench
=====================================

Name: device_axil_bridge

Overview:
- Converts the Aquila M_DEVICE master port (single-word, uncached, 0xC000_0000–0xCFFF_FFFF) into an AXI4-Lite master for peripheral IPs.
- Sits directly downstream of the Aquila top-level device port.
- Handles one transaction at a time and returns read data plus a one-cycle ready pulse to the core.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT_CYCLES, 1024, response watchdog limit. Used only with DEVBR_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- dev_strobe_i  in  1  request pulse from core
- dev_addr_i  in  XLEN  byte address
- dev_rw_i  in  1  1 = write, 0 = read
- dev_byte_enable_i  in  XLEN/8  write byte lanes
- dev_data_i  in  XLEN  write data
- dev_data_ready_o  out  1  one-cycle completion pulse
- dev_data_o  out  XLEN  read data; valid while dev_data_ready_o = 1
- dev_err_o  out  1  one-cycle pulse with ready when the response was non-OKAY or timed out
- m_axi_awaddr_o  out  XLEN
- m_axi_awprot_o  out  3  constant 3'b000
- m_axi_awvalid_o  out  1
- m_axi_awready_i  in  1
- m_axi_wdata_o  out  XLEN
- m_axi_wstrb_o  out  XLEN/8
- m_axi_wvalid_o  out  1
- m_axi_wready_i  in  1
- m_axi_bresp_i  in  2
- m_axi_bvalid_i  in  1
- m_axi_bready_o  out  1
- m_axi_araddr_o  out  XLEN
- m_axi_arprot_o  out  3  constant 3'b000
- m_axi_arvalid_o  out  1
- m_axi_arready_i  in  1
- m_axi_rdata_i  in  XLEN
- m_axi_rresp_i  in  2
- m_axi_rvalid_i  in  1
- m_axi_rready_o  out  1

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE; every valid/ready/pulse output 0; dev_data_o 0; address, data and strobe registers 0.
- FSM states: IDLE, WRITE, WR_RESP, READ, RD_DATA, DONE.
- IDLE:
  - dev_strobe_i = 1: latch addr, addr[1:0] forced to 0, plus data, byte enable and rw.
  - Write goes to WRITE with awvalid = wvalid = 1 from the next cycle. Read goes to READ with arvalid = 1 from the next cycle.
  - A write with byte_enable = 0 is still issued, with wstrb = 0.
- WRITE:
  - AW and W are handshaked independently. Each valid drops in the cycle after its own ready is seen high.
  - Order of awready/wready is arbitrary.
  - Move to WR_RESP once both have completed; the same-cycle case is allowed.
- WR_RESP: bready = 1. On bvalid, capture the error bit (bresp != 2'b00) and go to DONE.
- READ: arvalid held until arready, then RD_DATA. Valid must never depend on ready.
- RD_DATA: rready = 1. On rvalid, capture rdata; on non-OKAY rresp, store 0 and set the error bit. Go to DONE.
- DONE:
  - dev_data_ready_o = 1 for exactly one cycle; dev_data_o holds the captured data (0 for writes); dev_err_o = error bit.
  - Return to IDLE.
  - dev_data_o keeps its value until the next capture.
- dev_strobe_i outside IDLE is ignored. The core never issues a second request before ready.
- Minimum latency: strobe at cycle 0 with ready/valid answered immediately gives ready at cycle 3. This guarantees ready never arrives in the strobe cycle, which is required because the core-side mux registers its select by one cycle.
- A channel ready asserted before its valid has no effect.
- Reset mid-transaction aborts immediately with no pulse. The slave must be reset together with the bridge.

Optional Feature:
- Macro DEVBR_TIMEOUT_EN.
- When defined:
  - A counter clears on entering any non-IDLE/DONE state and increments each cycle the bridge waits.
  - When it reaches TIMEOUT_CYCLES-1: drop all valids and readies, go to DONE with data 32'hDEAD_BEEF and error bit 1.
  - A late response from the slave is subsequently ignored; the slave is presumed hung.
- When undefined: the bridge waits forever and the counter logic is absent.

Decomposition:
- Shared package (aquila_pkg) holds:
  - FSM state encoding typedef.
  - AXI response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - DEVBR_TIMEOUT_DATA = 32'hDEAD_BEEF.
- No sub-module is required. The optional watchdog counter may be isolated as devbr_watchdog (enable, clear, expired).

Test Plan:
- Write 0xC000_0004, data 0x1234_5678, be 4'b0011, slave always ready, OKAY → awaddr 0xC000_0004, wstrb 0011, ready pulse at cycle 3, err 0.
- Read 0xC000_0010, rdata 0xA5A5_0001 returned 5 cycles after arvalid → dev_data_o 0xA5A5_0001 with a single ready pulse; arvalid stable until arready.
- Write with wready 3 cycles before awready, then reverse order → exactly one AW and one W handshake each, one ready pulse.
- Read answered with rresp SLVERR → dev_data_o 0, dev_err_o 1 in the same cycle as ready.
- rst_ni low while in WR_RESP → all outputs 0 asynchronously; a subsequent read completes normally.
- DEVBR_TIMEOUT_EN, TIMEOUT_CYCLES 16, slave never asserts arready → ready with data 0xDEAD_BEEF and err 1 after 16 waiting cycles; arvalid low afterwards.

Source files
------------

// File: rtl/aquila_pkg.sv
// Shared definitions for the Aquila device-port AXI4-Lite bridge.
//   devbr_state_e      : bridge FSM state encoding
//   RESP_OKAY/SLVERR   : AXI response codes
//   DEVBR_TIMEOUT_DATA : read data returned when the watchdog fires
package aquila_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_WR_RESP = 3'd2,
    S_READ    = 3'd3,
    S_RD_DATA = 3'd4,
    S_DONE    = 3'd5
  } devbr_state_e;

  localparam logic [1:0]  RESP_OKAY          = 2'b00;
  localparam logic [1:0]  RESP_SLVERR        = 2'b10;
  localparam logic [31:0] DEVBR_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/device_axil_bridge_if.sv
// AXI4-Lite bus between the device bridge (master) and a peripheral (slave).
// Ports (master view):
//   out: awaddr awprot awvalid wdata wstrb wvalid bready araddr arprot arvalid rready
//   in : awready wready bresp bvalid arready rdata rresp rvalid
interface device_axil_bridge_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0]   awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [XLEN-1:0]   araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [XLEN-1:0]   rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/device_axil_bridge.sv
// Aquila M_DEVICE port to AXI4-Lite master bridge, one transaction at a time.
// Ports:
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   dev_*                   : core-side request (strobe/addr/rw/be/data) and
//                             response (ready pulse, read data, error pulse)
//   m_axi                   : AXI4-Lite master modport
// Build option: DEVBR_TIMEOUT_EN adds a response watchdog of TIMEOUT_CYCLES.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for dev_strobe_i
// S_WRITE   | AW and W offered, each dropped after its own handshake
// S_WR_RESP | bready high, waiting for bvalid
// S_READ    | arvalid held until arready
// S_RD_DATA | rready high, waiting for rvalid
// S_DONE    | one-cycle ready pulse to the core, then back to idle
module device_axil_bridge
  import aquila_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   dev_strobe_i,
  input  logic [XLEN-1:0]        dev_addr_i,
  input  logic                   dev_rw_i,
  input  logic [XLEN/8-1:0]      dev_byte_enable_i,
  input  logic [XLEN-1:0]        dev_data_i,
  output logic                   dev_data_ready_o,
  output logic [XLEN-1:0]        dev_data_o,
  output logic                   dev_err_o,
  device_axil_bridge_if.master   m_axi
);

  devbr_state_e      state_q, state_d;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN/8-1:0] wstrb_q;
  logic [XLEN-1:0]   data_q;
  logic              err_q;
  logic              aw_done_q, w_done_q;
  logic              timeout_hit;
  logic              wd_expired;
  logic              aw_hs, w_hs;

  // Word-aligned requests only; the low address bits are dropped on latch.
  logic unused_addr;
  assign unused_addr = ^dev_addr_i[1:0];

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = (state_q == S_WRITE) && !aw_done_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = (state_q == S_WRITE) && !w_done_q;
  assign m_axi.bready  = (state_q == S_WR_RESP);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = (state_q == S_READ);
  assign m_axi.rready  = (state_q == S_RD_DATA);

  assign aw_hs = m_axi.awvalid && m_axi.awready;
  assign w_hs  = m_axi.wvalid && m_axi.wready;

  assign dev_data_ready_o = (state_q == S_DONE);
  assign dev_data_o       = data_q;
  assign dev_err_o        = (state_q == S_DONE) && err_q;

`ifdef DEVBR_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt_q;

  assign wd_expired = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Restarts on every state change so each wait phase gets the full budget.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q <= '0;
    end else if (state_d != state_q) begin
      wd_cnt_q <= '0;
    end else if (state_q != S_IDLE && state_q != S_DONE) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      S_IDLE:    if (dev_strobe_i) state_d = dev_rw_i ? S_WRITE : S_READ;
      S_WRITE: begin
        // Same-cycle completion of both channels is allowed.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WR_RESP;
        else if (wd_expired)                            timeout_hit = 1'b1;
      end
      S_WR_RESP: begin
        if (m_axi.bvalid)    state_d = S_DONE;
        else if (wd_expired) timeout_hit = 1'b1;
      end
      S_READ: begin
        if (m_axi.arready)   state_d = S_RD_DATA;
        else if (wd_expired) timeout_hit = 1'b1;
      end
      S_RD_DATA: begin
        if (m_axi.rvalid)    state_d = S_DONE;
        else if (wd_expired) timeout_hit = 1'b1;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_DONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && dev_strobe_i) begin
        addr_q    <= {dev_addr_i[XLEN-1:2], 2'b00};
        wdata_q   <= dev_data_i;
        wstrb_q   <= dev_byte_enable_i;
        err_q     <= 1'b0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (state_q == S_WR_RESP && m_axi.bvalid) begin
        data_q <= '0;
        err_q  <= (m_axi.bresp != RESP_OKAY);
      end
      if (state_q == S_RD_DATA && m_axi.rvalid) begin
        if (m_axi.rresp != RESP_OKAY) begin
          data_q <= '0;
          err_q  <= 1'b1;
        end else begin
          data_q <= m_axi.rdata;
          err_q  <= 1'b0;
        end
      end
      if (timeout_hit) begin
        data_q <= XLEN'(DEVBR_TIMEOUT_DATA);
        err_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_device_axil_bridge.sv
// Directed bench for device_axil_bridge with a scoreboard: each issued request
// pushes its expected response; a monitor pops and compares on every ready pulse.
module tb_device_axil_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dev_strobe_i;
  logic [31:0] dev_addr_i;
  logic        dev_rw_i;
  logic [3:0]  dev_byte_enable_i;
  logic [31:0] dev_data_i;
  logic        dev_data_ready_o;
  logic [31:0] dev_data_o;
  logic        dev_err_o;

  device_axil_bridge_if #(.XLEN(32)) m_axi ();

  device_axil_bridge #(.XLEN(32), .TIMEOUT_CYCLES(16)) u_dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .dev_strobe_i      (dev_strobe_i),
    .dev_addr_i        (dev_addr_i),
    .dev_rw_i          (dev_rw_i),
    .dev_byte_enable_i (dev_byte_enable_i),
    .dev_data_i        (dev_data_i),
    .dev_data_ready_o  (dev_data_ready_o),
    .dev_data_o        (dev_data_o),
    .dev_err_o         (dev_err_o),
    .m_axi             (m_axi.master)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  int strobe_cyc = 0;

  // slave configuration and observations
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  bit ar_never = 1'b0;
  logic [31:0] r_data = '0;
  logic [1:0]  r_resp = 2'b00, b_resp = 2'b00;
  int aw_hs = 0, w_hs = 0, ar_unstable = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // AW channel
  initial begin
    m_axi.awready = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && m_axi.awvalid) begin
        repeat (aw_delay) @(negedge clk_i);
        m_axi.awready = 1'b1;
        last_awaddr = m_axi.awaddr;
        aw_hs++;
        @(negedge clk_i);
        m_axi.awready = 1'b0;
      end
    end
  end

  // W channel
  initial begin
    m_axi.wready = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && m_axi.wvalid) begin
        repeat (w_delay) @(negedge clk_i);
        m_axi.wready = 1'b1;
        last_wdata = m_axi.wdata;
        last_wstrb = m_axi.wstrb;
        w_hs++;
        @(negedge clk_i);
        m_axi.wready = 1'b0;
      end
    end
  end

  // B channel
  initial begin
    m_axi.bvalid = 1'b0;
    m_axi.bresp  = 2'b00;
    forever begin
      @(negedge clk_i);
      if (rst_ni && m_axi.bready) begin
        repeat (b_delay) @(negedge clk_i);
        m_axi.bvalid = 1'b1;
        m_axi.bresp  = b_resp;
        @(negedge clk_i);
        m_axi.bvalid = 1'b0;
        m_axi.bresp  = 2'b00;
      end
    end
  end

  // AR channel; also watches that arvalid stays up while arready is withheld
  initial begin
    m_axi.arready = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && m_axi.arvalid && !ar_never) begin
        for (int i = 0; i < ar_delay; i++) begin
          @(negedge clk_i);
          if (!m_axi.arvalid) ar_unstable++;
        end
        m_axi.arready = 1'b1;
        last_araddr = m_axi.araddr;
        @(negedge clk_i);
        m_axi.arready = 1'b0;
      end
    end
  end

  // R channel
  initial begin
    m_axi.rvalid = 1'b0;
    m_axi.rdata  = '0;
    m_axi.rresp  = 2'b00;
    forever begin
      @(negedge clk_i);
      if (rst_ni && m_axi.rready) begin
        repeat (r_delay) @(negedge clk_i);
        m_axi.rvalid = 1'b1;
        m_axi.rdata  = r_data;
        m_axi.rresp  = r_resp;
        @(negedge clk_i);
        m_axi.rvalid = 1'b0;
        m_axi.rdata  = '0;
        m_axi.rresp  = 2'b00;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && dev_data_ready_o) begin
        pulses++;
        if (exp_q.size() == 0) begin
          check("spurious_ready", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", dev_data_o, e.data);
          check("rsp_err", 32'(dev_err_o), 32'(e.err));
          if (e.lat >= 0) check("rsp_latency", 32'(cyc - strobe_cyc), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic rw, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_err, input int exp_lat);
    exp_t e;
    @(negedge clk_i);
    dev_strobe_i      = 1'b1;
    dev_rw_i          = rw;
    dev_addr_i        = addr;
    dev_byte_enable_i = be;
    dev_data_i        = wdata;
    strobe_cyc        = cyc;
    e.data = exp_data; e.err = exp_err; e.lat = exp_lat;
    exp_q.push_back(e);
    @(negedge clk_i);
    dev_strobe_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 300 && pulses < target; i++) @(negedge clk_i);
    check("complete", 32'(pulses), 32'(target));
    @(negedge clk_i);
  endtask

  task automatic run(input logic rw, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input logic [31:0] exp_data,
                     input logic exp_err, input int exp_lat);
    int target;
    target = pulses + 1;
    issue(rw, addr, be, wdata, exp_data, exp_err, exp_lat);
    wait_done(target);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awvalid"}, 32'(m_axi.awvalid), 32'd0);
    check({tag, "_wvalid"},  32'(m_axi.wvalid),  32'd0);
    check({tag, "_bready"},  32'(m_axi.bready),  32'd0);
    check({tag, "_arvalid"}, 32'(m_axi.arvalid), 32'd0);
    check({tag, "_rready"},  32'(m_axi.rready),  32'd0);
    check({tag, "_ready"},   32'(dev_data_ready_o), 32'd0);
    check({tag, "_err"},     32'(dev_err_o), 32'd0);
    check({tag, "_data"},    dev_data_o, 32'd0);
    check({tag, "_awaddr"},  m_axi.awaddr, 32'd0);
    check({tag, "_wstrb"},   32'(m_axi.wstrb), 32'd0);
  endtask

  initial begin
    int aw0, w0;
    rst_ni = 1'b0;
    dev_strobe_i = 1'b0; dev_rw_i = 1'b0; dev_addr_i = '0;
    dev_byte_enable_i = '0; dev_data_i = '0;
    repeat (3) @(negedge clk_i);
    check_idle_outputs("reset");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // basic write, slave always ready
    run(1'b1, 32'hC000_0004, 4'b0011, 32'h1234_5678, 32'h0, 1'b0, 3);
    check("w1_awaddr", last_awaddr, 32'hC000_0004);
    check("w1_wdata",  last_wdata,  32'h1234_5678);
    check("w1_wstrb",  32'(last_wstrb), 32'h3);
    check("w1_aw_hs",  32'(aw_hs), 32'd1);
    check("w1_w_hs",   32'(w_hs),  32'd1);

    // read: arready after 2 cycles, rvalid 5 cycles after arvalid first rose
    ar_delay = 2; r_delay = 2; r_data = 32'hA5A5_0001; r_resp = 2'b00;
    run(1'b0, 32'hC000_0013, 4'hF, 32'h0, 32'hA5A5_0001, 1'b0, 7);
    check("r1_araddr", last_araddr, 32'hC000_0010);
    check("r1_arvalid_stable", 32'(ar_unstable), 32'd0);
    ar_delay = 0; r_delay = 0;

    // read with SLVERR
    r_data = 32'hFFFF_FFFF; r_resp = 2'b10;
    run(1'b0, 32'hC000_0100, 4'hF, 32'h0, 32'h0, 1'b1, 3);
    r_resp = 2'b00;

    // wready 3 cycles ahead of awready, empty byte enable
    aw0 = aw_hs; w0 = w_hs;
    aw_delay = 3; w_delay = 0;
    run(1'b1, 32'hC000_0008, 4'b0000, 32'hCAFE_0001, 32'h0, 1'b0, 6);
    check("w2_aw_hs", 32'(aw_hs - aw0), 32'd1);
    check("w2_w_hs",  32'(w_hs - w0),   32'd1);
    check("w2_wstrb", 32'(last_wstrb),  32'h0);

    // reverse order
    aw0 = aw_hs; w0 = w_hs;
    aw_delay = 0; w_delay = 3;
    run(1'b1, 32'hC000_000C, 4'b1100, 32'hCAFE_0002, 32'h0, 1'b0, 6);
    check("w3_aw_hs", 32'(aw_hs - aw0), 32'd1);
    check("w3_w_hs",  32'(w_hs - w0),   32'd1);
    check("w3_wdata", last_wdata, 32'hCAFE_0002);
    w_delay = 0;

    // write answered with SLVERR
    b_resp = 2'b10;
    run(1'b1, 32'hC000_0040, 4'hF, 32'h0000_0001, 32'h0, 1'b1, 3);
    b_resp = 2'b00;

    // plain read, leaves non-zero data on dev_data_o
    r_data = 32'h5A5A_7777;
    run(1'b0, 32'hC000_0020, 4'hF, 32'h0, 32'h5A5A_7777, 1'b0, 3);

    // reset while waiting in WR_RESP
    b_delay = 10;
    issue(1'b1, 32'hC000_0050, 4'hF, 32'h7777_0000, 32'h0, 1'b0, -1);
    for (int i = 0; i < 20 && !m_axi.bready; i++) @(negedge clk_i);
    check("rst_reached_wr_resp", 32'(m_axi.bready), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("midrst");
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    b_delay = 0;
    repeat (15) @(negedge clk_i);

    // read after the aborted write
    r_data = 32'h0BAD_F00D;
    run(1'b0, 32'hC000_0030, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0, 3);
    check("r3_araddr", last_araddr, 32'hC000_0030);

`ifdef DEVBR_TIMEOUT_EN
    // slave never grants arready: 16 waiting cycles then a timeout response
    ar_never = 1'b1;
    run(1'b0, 32'hC000_0060, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1, 17);
    check("to_arvalid_low", 32'(m_axi.arvalid), 32'd0);
    ar_never = 1'b0;
`endif

    repeat (5) @(negedge clk_i);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
